// File: rtl/hexa_scan_ctrl_pkg.sv
// Shared types and constants for the hexa_scan_ctrl display sequencer.
package hexa_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    S_SHOW  = 2'd0,
    S_CONV  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  localparam logic [2:0] ANODE_OFF = 3'b111;

  localparam int unsigned DIG_UNI = 0;
  localparam int unsigned DIG_DEC = 1;
  localparam int unsigned DIG_CEN = 2;

  // Active-low one-hot anode enable for a digit slot.
  function automatic logic [2:0] anode_sel(logic [1:0] idx);
    return ~(3'b001 << idx);
  endfunction

endpackage

// File: rtl/hexa_scan_ctrl_if.sv
// Producer-side valid/ready handshake carrying the value to display.
interface hexa_scan_ctrl_if;
  logic [7:0] valor;
  logic       valor_valid;
  logic       valor_ready;

  modport master (output valor, output valor_valid, input valor_ready);
  modport slave  (input valor, input valor_valid, output valor_ready);
endinterface

// File: rtl/hexa_scan_prescaler.sv
// Digit-slot timebase: prescaler counter, slot index and slot-advance pulse.
module hexa_scan_prescaler
  import hexa_scan_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] idx,
  output logic       slot_tick
);

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic             terminal;

  assign terminal  = (cnt_q == TermCnt);
  // Gated by reset so the pulse stays low while held in reset, even for PRESCALE=1.
  assign slot_tick = terminal & rst_n;
  assign idx       = idx_q;

  // Count cycles within a slot and step the slot index 0->1->2->0 at terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'(DIG_UNI);
    end else if (terminal) begin
      cnt_q <= '0;
      idx_q <= (idx_q == 2'(DIG_CEN)) ? 2'(DIG_UNI) : idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/hexa_scan_ctrl.sv
// Load sequencer and 3-digit multiplexed display scanner around an external
// 8-bit-to-3-digit converter. Optional macro LEADING_BLANK_EN blanks leading zeros.
module hexa_scan_ctrl
  import hexa_scan_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hexa_scan_ctrl_if.slave  bus,
  output logic [7:0]       conv_entrada,
  input  logic [3:0]       conv_h1,
  input  logic [3:0]       conv_h2,
  input  logic [3:0]       conv_h3,
  output logic [3:0]       digito,
  output logic [2:0]       anodo,
  output logic             slot_tick
);

  state_t           state_q, state_d;
  logic             show_ready;
  logic             load;
  logic             latch;
  logic [2:0][3:0]  disp_q;
  logic [1:0]       idx;
  logic [3:0]       digit_d;
  logic [2:0]       anode_d;

  hexa_scan_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .slot_tick (slot_tick)
  );

  // Ready is forced low while reset is asserted.
  assign bus.valor_ready = show_ready & rst_n;

  // Load FSM next state: accept, give the converter one settle cycle, then latch digits.
  always_comb begin
    state_d    = state_q;
    show_ready = 1'b0;
    load       = 1'b0;
    latch      = 1'b0;
    unique case (state_q)
      S_SHOW: begin
        show_ready = 1'b1;
        if (bus.valor_valid) begin
          load    = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV:  state_d = S_LATCH;
      S_LATCH: begin
        latch   = 1'b1;
        state_d = S_SHOW;
      end
      default: state_d = S_SHOW;
    endcase
  end

  // FSM state, converter input and display registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_SHOW;
      conv_entrada <= '0;
      disp_q       <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        conv_entrada <= bus.valor;
      end
      if (latch) begin
        disp_q[DIG_UNI] <= conv_h1;
        disp_q[DIG_DEC] <= conv_h2;
        disp_q[DIG_CEN] <= conv_h3;
      end
    end
  end

  // Digit and anode selection for the current slot, with optional leading-zero blanking.
  always_comb begin
    digit_d = disp_q[DIG_UNI];
    case (idx)
      2'(DIG_DEC): digit_d = disp_q[DIG_DEC];
      2'(DIG_CEN): digit_d = disp_q[DIG_CEN];
      default:     digit_d = disp_q[DIG_UNI];
    endcase
    anode_d = anode_sel(idx);
`ifdef LEADING_BLANK_EN
    if (idx == 2'(DIG_CEN) && disp_q[DIG_CEN] == 4'd0) begin
      anode_d = ANODE_OFF;
    end
    if (idx == 2'(DIG_DEC) && disp_q[DIG_CEN] == 4'd0 && disp_q[DIG_DEC] == 4'd0) begin
      anode_d = ANODE_OFF;
    end
`endif
  end

  // Registered display outputs, one cycle behind idx/disp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digito <= '0;
      anodo  <= anode_sel(2'(DIG_UNI));
    end else begin
      digito <= digit_d;
      anodo  <= anode_d;
    end
  end

endmodule
